// File: rtl/bias_fetch_controller.sv
// Bias fetch controller: host loader writes, streamed in-order bias reads.
// Ports: clk/rst, start/busy/done, load_*, mem_* memory side, bias_* stream.
module bias_fetch_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_UNITS  = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_err,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  bias_valid,
  input  logic                  bias_ready,
  output logic [DATA_WIDTH-1:0] bias_data,
  output logic [ADDR_WIDTH-1:0] bias_index,
  output logic                  bias_last
);

  // One extra bit so NUM_UNITS == 2^ADDR_WIDTH stays representable.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_UNITS - 1);
  localparam logic [CW-1:0] NU   = CW'(NUM_UNITS);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state;
  logic [CW-1:0]         rd_cnt;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] infl_idx;
  logic                  infl_last;

  logic [DATA_WIDTH-1:0] f_data [2];
  logic [ADDR_WIDTH-1:0] f_idx  [2];
  logic                  f_last [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;
  logic [1:0]            next_count;

  logic push, pop, issue, accept, in_range;

  assign push = inflight;
  assign pop  = bias_valid && bias_ready;

  // A read is allowed only if its data will find a free slot;
  // a same-cycle pop frees one.
  assign issue = (state == FETCH) &&
    ((int'(fifo_count) + int'(inflight) - int'(pop)) < 2);

  assign next_count = fifo_count + {1'b0, push} - {1'b0, pop};

  assign mem_read_enable  = issue;
  assign mem_read_address = rd_cnt[ADDR_WIDTH-1:0];

  assign bias_valid = (fifo_count != 2'd0);
  assign bias_data  = f_data[rd_ptr];
  assign bias_index = f_idx[rd_ptr];
  assign bias_last  = f_last[rd_ptr];

  assign busy       = (state != IDLE);
  assign load_ready = (state == IDLE) && !start && !rst;
  assign accept     = load_valid && load_ready;
  assign in_range   = ({1'b0, load_addr} < NU);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      rd_cnt            <= '0;
      inflight          <= 1'b0;
      infl_idx          <= '0;
      infl_last         <= 1'b0;
      wr_ptr            <= 1'b0;
      rd_ptr            <= 1'b0;
      fifo_count        <= 2'd0;
      done              <= 1'b0;
      load_err          <= 1'b0;
      mem_write_enable  <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_idx[i]  <= '0;
        f_last[i] <= 1'b0;
      end
    end else begin
      done              <= 1'b0;
      mem_write_enable  <= accept && in_range;
      mem_write_address <= accept ? load_addr : '0;
      mem_write_data    <= accept ? load_data : '0;
      if (accept && !in_range)
        load_err <= 1'b1;

      inflight <= issue;
      if (issue) begin
        infl_idx  <= rd_cnt[ADDR_WIDTH-1:0];
        infl_last <= (rd_cnt == LAST);
        rd_cnt    <= rd_cnt + 1'b1;
      end

      if (push) begin
        f_data[wr_ptr] <= mem_read_data;
        f_idx[wr_ptr]  <= infl_idx;
        f_last[wr_ptr] <= infl_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      fifo_count <= next_count;

      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= FETCH;
            rd_cnt <= '0;
          end
        end
        FETCH: begin
          if (issue && rd_cnt == LAST)
            state <= DRAIN;
        end
        DRAIN: begin
          if (next_count == 2'd0) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_fetch_controller.sv
// Scoreboard bench for bias_fetch_controller (NUM_UNITS=100 and =1).
// Ports: none; drives both instances and models their memories.
module tb_bias_fetch_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [6:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic        load_err;
  logic        mem_write_enable;
  logic [6:0]  mem_write_address;
  logic [15:0] mem_write_data;
  logic        mem_read_enable;
  logic [6:0]  mem_read_address;
  logic [15:0] mem_read_data = '0;
  logic        bias_valid;
  logic        bias_ready = 1'b0;
  logic [15:0] bias_data;
  logic [6:0]  bias_index;
  logic        bias_last;

  bias_fetch_controller #(
    .DATA_WIDTH(16), .ADDR_WIDTH(7), .NUM_UNITS(100)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data),
    .load_err(load_err),
    .mem_write_enable(mem_write_enable),
    .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .mem_read_enable(mem_read_enable),
    .mem_read_address(mem_read_address),
    .mem_read_data(mem_read_data),
    .bias_valid(bias_valid), .bias_ready(bias_ready),
    .bias_data(bias_data), .bias_index(bias_index),
    .bias_last(bias_last)
  );

  logic        s_start = 1'b0;
  logic        s_busy, s_done;
  logic        s_load_valid = 1'b0;
  logic        s_load_ready;
  logic [6:0]  s_load_addr = '0;
  logic [15:0] s_load_data = '0;
  logic        s_load_err;
  logic        s_mwe;
  logic [6:0]  s_mwa;
  logic [15:0] s_mwd;
  logic        s_mre;
  logic [6:0]  s_mra;
  logic [15:0] s_mrd = '0;
  logic        s_bias_valid;
  logic        s_bias_ready = 1'b1;
  logic [15:0] s_bias_data;
  logic [6:0]  s_bias_index;
  logic        s_bias_last;

  bias_fetch_controller #(
    .DATA_WIDTH(16), .ADDR_WIDTH(7), .NUM_UNITS(1)
  ) u1 (
    .clk(clk), .rst(rst), .start(s_start),
    .busy(s_busy), .done(s_done),
    .load_valid(s_load_valid), .load_ready(s_load_ready),
    .load_addr(s_load_addr), .load_data(s_load_data),
    .load_err(s_load_err),
    .mem_write_enable(s_mwe),
    .mem_write_address(s_mwa),
    .mem_write_data(s_mwd),
    .mem_read_enable(s_mre),
    .mem_read_address(s_mra),
    .mem_read_data(s_mrd),
    .bias_valid(s_bias_valid), .bias_ready(s_bias_ready),
    .bias_data(s_bias_data), .bias_index(s_bias_index),
    .bias_last(s_bias_last)
  );

  logic [15:0] mem   [128];
  logic [15:0] s_mem [128];

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_write_address] <= mem_write_data;
    if (mem_read_enable)  mem_read_data <= mem[mem_read_address];
    if (s_mwe) s_mem[s_mwa] <= s_mwd;
    if (s_mre) s_mrd <= s_mem[s_mra];
  end

  typedef struct packed {
    logic [15:0] d;
    logic [6:0]  i;
    logic        l;
  } beat_t;

  beat_t       sb [$];
  logic [15:0] exp_mem [100];
  logic        err_exp = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          beats = 0;
  int          rmode = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Ready pattern: mode 0 always 1, mode 1 repeats 1,0,0,1.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0) bias_ready = 1'b1;
      else begin
        bias_ready = (ph == 0 || ph == 3);
        ph = (ph + 1) % 4;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted beat.
  logic  stall_prev = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    beat_t e;
    chk("occupancy",
        32'((int'(dut.fifo_count) + int'(dut.inflight)) <= 2), 1);
    if (rst) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        chk("stall_valid", bias_valid, 1);
        chk("stall_hold", {bias_data, bias_index, bias_last}, held);
      end
      if (bias_valid && bias_ready) begin
        if (sb.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = sb.pop_front();
          chk("beat_data", bias_data, e.d);
          chk("beat_index", bias_index, e.i);
          chk("beat_last", bias_last, e.l);
          beats++;
        end
      end
      stall_prev = bias_valid && !bias_ready;
      held = {bias_data, bias_index, bias_last};
    end
  end

  task automatic load(input logic [6:0] a, input logic [15:0] d);
    int w = 0;
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    @(negedge clk);
    while (!load_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("load_ready_wait", load_ready, 1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    chk("wr_en", mem_write_enable, a < 7'd100);
    if (a < 7'd100) begin
      chk("wr_addr", mem_write_address, a);
      chk("wr_data", mem_write_data, d);
      exp_mem[a] = d;
    end else err_exp = 1'b1;
    chk("load_err", load_err, err_exp);
  endtask

  task automatic push_pass();
    for (int k = 0; k < 100; k++)
      sb.push_back({exp_mem[k], 7'(k), k == 99});
  endtask

  task automatic run_pass(input bit timed, input bit coll);
    int first = -1;
    int dcyc = -1;
    int lr_bad = 0;
    beats = 0;
    push_pass();
    start = 1'b1;
    if (coll) begin
      load_valid = 1'b1;
      load_addr  = 7'd5;
      load_data  = 16'hBEEF;
      #1;
      chk("coll_ready", load_ready, 0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("pass_busy", busy, 1);
    if (coll) chk("coll_no_wr", mem_write_enable, 0);
    for (int c = 1; c <= 2000 && dcyc < 0; c++) begin
      @(negedge clk);
      if (c == 6) load_valid = 1'b0;
      if (bias_valid && first < 0) first = c;
      if (busy && load_ready) lr_bad++;
      if (done) dcyc = c;
    end
    chk("done_seen", dcyc >= 0, 1);
    chk("ready_while_busy", lr_bad, 0);
    chk("beat_count", beats, 100);
    chk("sb_empty", sb.size(), 0);
    if (timed) begin
      chk("first_valid_cyc", first, 3);
      chk("done_cyc", dcyc, 103);
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    int w;
    int first;
    int dcyc;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", bias_valid, 0);
    chk("rst_re", mem_read_enable, 0);
    chk("rst_we", mem_write_enable, 0);
    chk("rst_err", load_err, 0);
    chk("rst_lready", load_ready, 0);
    chk("rst_data", bias_data, 0);
    rst = 1'b0;
    #1;
    chk("idle_lready", load_ready, 1);

    // Single-unit instance.
    s_load_valid = 1'b1;
    s_load_addr  = 7'd0;
    s_load_data  = 16'h1234;
    @(posedge clk);
    #1;
    chk("s_wr_en", s_mwe, 1);
    s_load_addr = 7'd1;
    s_load_data = 16'h1111;
    @(posedge clk);
    #1;
    s_load_valid = 1'b0;
    chk("s_oor_we", s_mwe, 0);
    chk("s_err", s_load_err, 1);
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    first = -1;
    dcyc  = -1;
    for (int c = 1; c <= 20 && dcyc < 0; c++) begin
      @(negedge clk);
      if (s_bias_valid && first < 0) begin
        first = c;
        chk("s_data", s_bias_data, 16'h1234);
        chk("s_index", s_bias_index, 0);
        chk("s_last", s_bias_last, 1);
      end
      if (s_done) dcyc = c;
    end
    chk("s_first_cyc", first, 3);
    chk("s_done_cyc", dcyc, 4);
    @(posedge clk);
    #1;

    // Load then fetch; the last write lands right before start.
    for (int k = 0; k < 100; k++)
      load(7'(k), 16'(16'h0100 + k));
    run_pass(1, 0);

    // Backpressure.
    rmode = 1;
    run_pass(0, 0);
    rmode = 0;
    @(posedge clk);
    #1;

    // Collision: start beats a simultaneous load.
    run_pass(1, 1);

    // Out-of-range load, then a valid one, then a pass.
    load(7'd100, 16'h7FFF);
    load(7'd3, 16'h0333);
    run_pass(1, 0);

    // Reset in mid-pass.
    beats = 0;
    push_pass();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    w = 0;
    while (beats < 40 && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("reach_beat40", beats >= 40, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    chk("mr_busy", busy, 0);
    chk("mr_valid", bias_valid, 0);
    chk("mr_done", done, 0);
    chk("mr_re", mem_read_enable, 0);
    chk("mr_raddr", mem_read_address, 0);
    chk("mr_out", {bias_data, bias_index, bias_last}, 0);
    chk("mr_err", load_err, 0);
    err_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_pass(1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
